pll_rst_seq: RTL and testbench
==============================

Name: pll_rst_seq

Overview:
- PLL lock qualifier and design reset sequencer; sits directly downstream of the PLL and user-reset cells.
- Consumes the PLL lock flag and the user reset.
- Produces a glitch-filtered, synchronously deasserted design reset, a ready flag, and a PLL re-lock request pulse on lock timeout.
- Clocked by the free-running reference clock, never by a PLL output.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for PLL_LOCKED and USR_RSTN (min 2).
- LOCK_FILTER, 16, consecutive cycles lock must stay high before release sequencing (min 1).
- RST_HOLD, 8, extra cycles RST_OUT stays high after the filter passes (min 1).
- RELOCK_TIMEOUT, 1024, cycles in WAIT_LOCK before a PLL reset request (min 2).
- PLL_RST_PULSE, 4, width of the PLL_RST_REQ pulse in cycles (min 1).

Ports:
- CLK, in, 1, free-running reference clock.
- RST, in, 1, asynchronous active-high reset.
- PLL_LOCKED, in, 1, PLL lock flag; asynchronous to CLK.
- USR_RSTN, in, 1, user reset, active low; asynchronous.
- RST_OUT, out, 1, design reset, active high; asserted asynchronously by RST, deasserted synchronously.
- READY, out, 1, high only in RUN.
- PLL_RST_REQ, out, 1, re-lock request to the PLL steady-reset input.
- STATE, out, 3, current FSM state encoding, for debug.

Behaviour:
- Reset (RST=1), asynchronous: synchronizers cleared to 0; FSM to WAIT_LOCK; counter 0; RST_OUT=1, READY=0, PLL_RST_REQ=0.
- lock_s and urstn_s are the SYNC_STAGES-deep synchronized inputs. All outputs are registered.
- States: WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3, PLL_RST=4. Other encodings go to WAIT_LOCK.
- One shared counter cnt, width from the package; it is cleared on every state change.
- WAIT_LOCK:
  - lock_s=1 -> FILTER.
  - Otherwise cnt increments; at cnt==RELOCK_TIMEOUT-1 -> PLL_RST.
- FILTER:
  - lock_s=0 -> WAIT_LOCK.
  - At cnt==LOCK_FILTER-1 with lock_s=1 -> HOLD.
- HOLD:
  - lock_s=0 -> WAIT_LOCK.
  - At cnt==RST_HOLD-1 -> RUN.
- RUN:
  - RST_OUT=0 and READY=1, both registered and visible the cycle after entry.
  - lock_s=0 -> WAIT_LOCK; RST_OUT=1 and READY=0 on the next edge.
- PLL_RST:
  - PLL_RST_REQ=1 for exactly PLL_RST_PULSE cycles, then WAIT_LOCK.
  - lock_s is ignored while pulsing.
- RST_OUT=1 in every state except RUN.
- Latency: from the first edge sampling PLL_LOCKED=1 to RST_OUT=0 is exactly SYNC_STAGES+LOCK_FILTER+RST_HOLD+1 edges, given lock stays high.
- urstn_s=0 has priority over all lock events in every state:
  - FSM to WAIT_LOCK and cnt cleared.
  - RST_OUT=1, READY=0, PLL_RST_REQ=0 on the next edge.
  - The timeout counter does not advance while urstn_s=0.
- Lock glitches shorter than LOCK_FILTER cycles never release reset.
- A lock drop during FILTER or HOLD restarts the sequence with no PLL request.
- RST assertion mid-operation aborts immediately, including a PLL_RST pulse in progress.

Optional Feature:
- Macro: PLL_RST_SEQ_STATUS_EN.
- When defined, add two output ports:
  - LOSS_CNT[7:0]: increments on each RUN->WAIT_LOCK transition caused by lock_s=0; saturates at 255.
  - TIMEOUT_CNT[7:0]: increments on each WAIT_LOCK->PLL_RST transition; saturates at 255.
  - Both clear on RST only; USR_RSTN does not clear them.
- When undefined, the ports and logic are absent and core behaviour is identical.

Decomposition:
- Package pll_rst_seq_pkg holds:
  - state enum typedef (3 bits, encodings as above);
  - function computing counter width as clog2 of max(LOCK_FILTER, RST_HOLD, RELOCK_TIMEOUT, PLL_RST_PULSE) + 1.
- One sub-module: pll_rst_sync, a parameterized SYNC_STAGES flop chain with async clear. It is instantiated twice (PLL_LOCKED, USR_RSTN).

Test Plan:
- Sequenced release:
  - Setup: SYNC_STAGES=2, LOCK_FILTER=4, RST_HOLD=3; USR_RSTN=1, RST released; PLL_LOCKED rises and stays high.
  - Required: RST_OUT falls exactly 10 edges after lock is first sampled; READY rises the same cycle.
- Lock glitch:
  - Stimulus: PLL_LOCKED high for 3 cycles, then low (LOCK_FILTER=4).
  - Required: FSM returns to WAIT_LOCK; RST_OUT stays 1; PLL_RST_REQ stays 0.
- Lock loss in RUN:
  - Stimulus: drop PLL_LOCKED.
  - Required: RST_OUT=1 at SYNC_STAGES+1 edges later; READY=0; with PLL_RST_SEQ_STATUS_EN, LOSS_CNT goes 0->1.
- Timeout:
  - Setup: RELOCK_TIMEOUT=8, PLL_RST_PULSE=4; lock never asserted.
  - Required: PLL_RST_REQ high for exactly 4 cycles after 8 WAIT_LOCK cycles, then repeats.
- User reset mid-HOLD:
  - Stimulus: USR_RSTN low 1 cycle.
  - Required: FSM to WAIT_LOCK; full sequence restarts; RST_OUT never drops early.
- Async RST during a PLL_RST pulse:
  - Required: PLL_RST_REQ=0 immediately without a clock edge; RST_OUT=1; STATE=0.

Source files
------------

// File: rtl/pll_rst_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock qualifier / reset sequencer.
package pll_rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        PLL_RST   = 3'd4
    } state_t;

    function automatic int unsigned cnt_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_rst_sync.sv
// SYNC_STAGES-deep flop chain for an asynchronous level input; clears to 0 on rst.
module pll_rst_sync
    import pll_rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL lock qualifier and design reset sequencer on the free-running reference clock.
// Optional status counters (LOSS_CNT, TIMEOUT_CNT) are built with PLL_RST_SEQ_STATUS_EN.
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned LOCK_FILTER    = 16,
    parameter int unsigned RST_HOLD       = 8,
    parameter int unsigned RELOCK_TIMEOUT = 1024,
    parameter int unsigned PLL_RST_PULSE  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PLL_LOCKED,
    input  logic       USR_RSTN,
    output logic       RST_OUT,
    output logic       READY,
    output logic       PLL_RST_REQ,
    output logic [2:0] STATE
`ifdef PLL_RST_SEQ_STATUS_EN
    ,
    output logic [7:0] LOSS_CNT,
    output logic [7:0] TIMEOUT_CNT
`endif
);

    localparam int unsigned CW = cnt_width(LOCK_FILTER, RST_HOLD, RELOCK_TIMEOUT, PLL_RST_PULSE);
    localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RELOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(PLL_RST_PULSE - 1);

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          lock_s, urstn_s;

    pll_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (CLK),
        .rst (RST),
        .d   (PLL_LOCKED),
        .q   (lock_s)
    );

    pll_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_urstn_sync (
        .clk (CLK),
        .rst (RST),
        .d   (USR_RSTN),
        .q   (urstn_s)
    );

    always_comb begin
        next_state = state;
        next_cnt   = cnt + CW'(1);
        case (state)
            WAIT_LOCK: begin
                if (lock_s)                   next_state = FILTER;
                else if (cnt == TIMEOUT_LAST) next_state = PLL_RST;
            end
            FILTER: begin
                if (!lock_s)                 next_state = WAIT_LOCK;
                else if (cnt == FILTER_LAST) next_state = HOLD;
            end
            HOLD: begin
                if (!lock_s)               next_state = WAIT_LOCK;
                else if (cnt == HOLD_LAST) next_state = RUN;
            end
            RUN: begin
                next_cnt = cnt;
                if (!lock_s) next_state = WAIT_LOCK;
            end
            PLL_RST: begin
                if (cnt == PULSE_LAST) next_state = WAIT_LOCK;
            end
            default: next_state = WAIT_LOCK;
        endcase
        // User reset overrides every lock event and freezes the timeout count.
        if (!urstn_s) next_state = WAIT_LOCK;
        if (!urstn_s || next_state != state) next_cnt = '0;
    end

    // Outputs are registered from next_state so they track the state register exactly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            RST_OUT     <= 1'b1;
            READY       <= 1'b0;
            PLL_RST_REQ <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            RST_OUT     <= (next_state != RUN);
            READY       <= (next_state == RUN);
            PLL_RST_REQ <= (next_state == PLL_RST);
        end
    end

    assign STATE = state;

`ifdef PLL_RST_SEQ_STATUS_EN
    logic loss_evt, timeout_evt;

    assign loss_evt    = (state == RUN) && urstn_s && !lock_s;
    assign timeout_evt = (state == WAIT_LOCK) && (next_state == PLL_RST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LOSS_CNT    <= '0;
            TIMEOUT_CNT <= '0;
        end else begin
            if (loss_evt && LOSS_CNT != '1)       LOSS_CNT    <= LOSS_CNT + 8'd1;
            if (timeout_evt && TIMEOUT_CNT != '1) TIMEOUT_CNT <= TIMEOUT_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq (small parameters: 2/4/3/8/4).
module tb_pll_rst_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PLL_LOCKED;
    logic       USR_RSTN;
    logic       RST_OUT;
    logic       READY;
    logic       PLL_RST_REQ;
    logic [2:0] STATE;
`ifdef PLL_RST_SEQ_STATUS_EN
    logic [7:0] LOSS_CNT;
    logic [7:0] TIMEOUT_CNT;
`endif

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    always #5 CLK = ~CLK;

    pll_rst_seq #(
        .SYNC_STAGES    (2),
        .LOCK_FILTER    (4),
        .RST_HOLD       (3),
        .RELOCK_TIMEOUT (8),
        .PLL_RST_PULSE  (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PLL_LOCKED  (PLL_LOCKED),
        .USR_RSTN    (USR_RSTN),
        .RST_OUT     (RST_OUT),
        .READY       (READY),
        .PLL_RST_REQ (PLL_RST_REQ),
        .STATE       (STATE)
`ifdef PLL_RST_SEQ_STATUS_EN
        ,
        .LOSS_CNT    (LOSS_CNT),
        .TIMEOUT_CNT (TIMEOUT_CNT)
`endif
    );

    typedef struct {
        logic        lock;
        logic        urstn;
        int unsigned cycles;
        logic [2:0]  state;
        logic        rst_out;
        logic        ready;
        logic        req;
        logic [7:0]  loss;
        logic [7:0]  tmo;
    } vec_t;

    typedef struct {
        int unsigned idx;
        logic [2:0]  state;
        logic        rst_out;
        logic        ready;
        logic        req;
        logic [7:0]  loss;
        logic [7:0]  tmo;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Counts posedges until the selected output (0: RST_OUT, 1: PLL_RST_REQ) equals val; 0 on timeout.
    task automatic edges_until(input int sel, input logic val, input int unsigned limit,
                               output int unsigned n);
        n = 0;
        for (int unsigned i = 1; i <= limit; i++) begin
            @(posedge CLK);
            #1;
            if (((sel == 0) ? RST_OUT : PLL_RST_REQ) === val) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        PLL_LOCKED = 1'b0;
        USR_RSTN   = 1'b1;
        #1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state",   32'(STATE),       32'd0);
        check("reset_rst_out", 32'(RST_OUT),     32'd1);
        check("reset_ready",   32'(READY),       32'd0);
        check("reset_req",     32'(PLL_RST_REQ), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        exp_t        e;

        // Sequenced release, then lock loss in RUN.
        do_reset();
        repeat (3) @(negedge CLK);
        PLL_LOCKED = 1'b1;
        edges_until(0, 1'b0, 40, n);
        check("release_latency", n, 10);
        check("release_ready",   32'(READY), 32'd1);
        check("release_state",   32'(STATE), 32'd3);
        PLL_LOCKED = 1'b0;
        edges_until(0, 1'b1, 20, n);
        check("loss_latency", n, 3);
        check("loss_ready",   32'(READY), 32'd0);
        check("loss_state",   32'(STATE), 32'd0);
`ifdef PLL_RST_SEQ_STATUS_EN
        check("loss_cnt", 32'(LOSS_CNT), 32'd1);
`endif

        // Glitch, timeout, user reset mid-HOLD, full release, loss, held user reset.
        vecs.push_back('{1'b0, 1'b1,  2, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        vecs.push_back('{1'b1, 1'b1,  3, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        vecs.push_back('{1'b0, 1'b1,  1, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        vecs.push_back('{1'b0, 1'b1,  2, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        vecs.push_back('{1'b0, 1'b1,  7, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        vecs.push_back('{1'b0, 1'b1,  1, 3'd4, 1'b1, 1'b0, 1'b1, 8'd0, 8'd1});
        vecs.push_back('{1'b1, 1'b1,  3, 3'd4, 1'b1, 1'b0, 1'b1, 8'd0, 8'd1});
        vecs.push_back('{1'b1, 1'b1,  1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1});
        vecs.push_back('{1'b1, 1'b1,  1, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1});
        vecs.push_back('{1'b1, 1'b1,  4, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1});
        vecs.push_back('{1'b1, 1'b0,  1, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1});
        vecs.push_back('{1'b1, 1'b1,  1, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1});
        vecs.push_back('{1'b1, 1'b1,  1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1});
        vecs.push_back('{1'b1, 1'b1,  1, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1});
        vecs.push_back('{1'b1, 1'b1,  6, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1});
        vecs.push_back('{1'b1, 1'b1,  1, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1});
        vecs.push_back('{1'b0, 1'b1,  2, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1});
        vecs.push_back('{1'b0, 1'b1,  1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1});
        vecs.push_back('{1'b0, 1'b0, 20, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1});
        vecs.push_back('{1'b0, 1'b1,  9, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1});
        vecs.push_back('{1'b0, 1'b1,  1, 3'd4, 1'b1, 1'b0, 1'b1, 8'd1, 8'd2});
        vecs.push_back('{1'b0, 1'b1,  4, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2});

        do_reset();
        for (int unsigned i = 0; i < vecs.size(); i++) begin
            PLL_LOCKED = vecs[i].lock;
            USR_RSTN   = vecs[i].urstn;
            sb.push_back('{i, vecs[i].state, vecs[i].rst_out, vecs[i].ready, vecs[i].req,
                           vecs[i].loss, vecs[i].tmo});
            repeat (vecs[i].cycles) @(posedge CLK);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_state",   e.idx), 32'(STATE),       32'(e.state));
            check($sformatf("vec%0d_rst_out", e.idx), 32'(RST_OUT),     32'(e.rst_out));
            check($sformatf("vec%0d_ready",   e.idx), 32'(READY),       32'(e.ready));
            check($sformatf("vec%0d_req",     e.idx), 32'(PLL_RST_REQ), 32'(e.req));
`ifdef PLL_RST_SEQ_STATUS_EN
            check($sformatf("vec%0d_loss", e.idx), 32'(LOSS_CNT),    32'(e.loss));
            check($sformatf("vec%0d_tmo",  e.idx), 32'(TIMEOUT_CNT), 32'(e.tmo));
`endif
            @(negedge CLK);
        end

        // Timeout pulse width and repeat, then async RST mid-pulse.
        do_reset();
        edges_until(1, 1'b1, 40, n);
        check("timeout_first_rise", n, 10);
        edges_until(1, 1'b0, 40, n);
        check("timeout_pulse_width", n, 4);
        edges_until(1, 1'b1, 40, n);
        check("timeout_gap", n, 8);
        check("timeout_state", 32'(STATE), 32'd4);
`ifdef PLL_RST_SEQ_STATUS_EN
        check("timeout_cnt", 32'(TIMEOUT_CNT), 32'd2);
`endif
        #2;
        RST = 1'b1;
        #1;
        check("async_req",     32'(PLL_RST_REQ), 32'd0);
        check("async_rst_out", 32'(RST_OUT),     32'd1);
        check("async_state",   32'(STATE),       32'd0);
`ifdef PLL_RST_SEQ_STATUS_EN
        check("async_tmo_clr", 32'(TIMEOUT_CNT), 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
